// File: rtl/ql_irq_ctrl.sv
// ql_irq_ctrl: synchronous interrupt controller for the QL core.
// Collects N active-high sources, applies per-channel mask and edge/level mode,
// keeps write-1-to-clear pending bits, and folds the result into the 68008
// active-low IPL pair coming from the IPC.
//
// Register map (16-bit bus, bit i = channel i, bits >= N read 0):
//   addr 0 : pending (read) / write-1-to-clear
//   addr 1 : mask (R/W)
//   addr 2 : mode (R/W), 0 = edge, 1 = level
//   addr 3 : raw source after optional synchroniser (read) / write-1-to-set
//
// Optional build macro IRQ_SYNC_EN: when defined, every source bit passes
// through a 2-flop synchroniser before gating (adds 2 cycles of latency, and
// addr 3 reads the synchronised value). When undefined, src is used directly.
//
// All flops are clocked by clk and cleared by the synchronous, active-high reset.

module ql_irq_ctrl #(
   parameter int           N        = 8,
   parameter logic [1:0]   PEND_IPL = 2'b01,
   parameter logic [N-1:0] MODE_RST = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cen,
   input  logic         cpu_sel,
   input  logic         cpu_wr,
   input  logic [1:0]   cpu_addr,
   input  logic         cpu_uds,
   input  logic         cpu_lds,
   input  logic [15:0]  cpu_din,
   output logic [15:0]  cpu_dout,
   input  logic [N-1:0] src,
   input  logic [1:0]   ipc_ipl,
   output logic [1:0]   ipl,
   output logic         irq_any
);

   localparam logic [1:0] ADDR_PEND = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_MODE = 2'd2;
   localparam logic [1:0] ADDR_SRC  = 2'd3;

   // Zero-extend an N-bit channel vector onto the 16-bit data bus.
   function automatic logic [15:0] to_bus(input logic [N-1:0] v);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < N; i++) begin
         r[i] = v[i];
      end
      return r;
   endfunction

   // Merge write data into a register value under a per-bit write enable.
   function automatic logic [N-1:0] merge_bits(input logic [N-1:0] old_v,
                                               input logic [N-1:0] new_v,
                                               input logic [N-1:0] en_v);
      return (old_v & ~en_v) | (new_v & en_v);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [N-1:0] pending_q, pending_d;
   logic [N-1:0] mask_q,    mask_d;
   logic [N-1:0] mode_q,    mode_d;
   logic [N-1:0] gate_q,    gate_d;     // previous gated input (g_d)
   logic         irq_any_q, irq_any_d;
   logic [1:0]   ipl_q,     ipl_d;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic         bus_we_s;
   logic [N-1:0] lane_en_s;     // byte-lane enable mapped onto channels
   logic [N-1:0] wdata_s;       // write data restricted to enabled lanes
   logic [N-1:0] ack_s;         // W1C bits this cycle
   logic [N-1:0] swset_s;       // software-trigger bits this cycle
   logic [N-1:0] src_s;         // source after optional synchroniser
   logic [N-1:0] gated_s;       // src_s & mask
   logic [N-1:0] set_s;         // hardware set bits this cycle
   logic         unused_din_s;

   // Bits of cpu_din above the channel count never reach a register.
   assign unused_din_s = ^cpu_din;

   assign bus_we_s = cen & cpu_sel & cpu_wr;

`ifdef IRQ_SYNC_EN
   logic [N-1:0] sync1_q;
   logic [N-1:0] sync2_q;

   // Two-stage synchroniser on every source bit, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src;
`endif

   // Byte enables: upper lane (bits 15:8) follows uds, lower lane follows lds.
   always_comb begin
      lane_en_s = '0;
      wdata_s   = '0;
      for (int i = 0; i < N; i++) begin
         if (i >= 32'sd8) begin
            lane_en_s[i] = cpu_uds;
         end else begin
            lane_en_s[i] = cpu_lds;
         end
         wdata_s[i] = cpu_din[i] & lane_en_s[i];
      end
   end

   // Decode the bus strobe into per-register write actions.
   always_comb begin
      ack_s   = '0;
      swset_s = '0;
      mask_d  = mask_q;
      mode_d  = mode_q;
      if (bus_we_s) begin
         case (cpu_addr)
            ADDR_PEND: ack_s   = wdata_s;
            ADDR_MASK: mask_d  = merge_bits(mask_q, wdata_s, lane_en_s);
            ADDR_MODE: mode_d  = merge_bits(mode_q, wdata_s, lane_en_s);
            ADDR_SRC:  swset_s = wdata_s;
            default: begin
               ack_s   = '0;
               swset_s = '0;
            end
         endcase
      end else begin
         ack_s   = '0;
         swset_s = '0;
      end
   end

   // Per-channel set detection: rising edge of the gated input for edge
   // channels, gated level for level channels. Set beats ack so a new
   // event arriving on the acknowledge cycle is never lost.
   always_comb begin
      gated_s   = src_s & mask_q;
      set_s     = (mode_q & gated_s) | (~mode_q & gated_s & ~gate_q);
      gate_d    = gated_s;
      pending_d = (pending_q & ~ack_s) | set_s | swset_s;
   end

   // Output next state is derived from the registered pending vector, so
   // irq_any and ipl trail pending by one clock.
   always_comb begin
      irq_any_d = |pending_q;
      if (irq_any_d) begin
         ipl_d = ipc_ipl & PEND_IPL;
      end else begin
         ipl_d = ipc_ipl;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         mask_q    <= '0;
         mode_q    <= MODE_RST;
         gate_q    <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         gate_q    <= gate_d;
      end
   end

   // Registered CPU-facing outputs; IPL idles at level 0 (both lines high).
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_any_q <= 1'b0;
         ipl_q     <= 2'b11;
      end else begin
         irq_any_q <= irq_any_d;
         ipl_q     <= ipl_d;
      end
   end

   // Read multiplexer, combinational from the register index.
   always_comb begin
      cpu_dout = 16'h0000;
      case (cpu_addr)
         ADDR_PEND: cpu_dout = to_bus(pending_q);
         ADDR_MASK: cpu_dout = to_bus(mask_q);
         ADDR_MODE: cpu_dout = to_bus(mode_q);
         ADDR_SRC:  cpu_dout = to_bus(src_s);
         default:   cpu_dout = 16'h0000;
      endcase
   end

   assign irq_any = irq_any_q;
   assign ipl     = ipl_q;

endmodule

// File: tb/tb_ql_irq_ctrl.sv
// Self-checking bench for ql_irq_ctrl (N = 16). A word-level reference model
// tracks pending/mask/mode and the expected outputs; a compare process checks
// ipl, irq_any and cpu_dout on every falling edge. Directed scenarios add
// literal expectations, then a randomized phase drives bus traffic and sources.
// Build with IRQ_SYNC_EN defined to exercise the synchroniser variant.

module tb_ql_irq_ctrl;

   localparam int          N    = 16;
   localparam logic [1:0]  PEND = 2'b01;
   localparam logic [15:0] MRST = 16'hA5C0;
`ifdef IRQ_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = SYNC + 1;

   logic        clk = 1'b0;
   logic        reset, cen, cpu_sel, cpu_wr, cpu_uds, cpu_lds;
   logic [1:0]  cpu_addr;
   logic [15:0] cpu_din, cpu_dout, src;
   logic [1:0]  ipc_ipl, ipl;
   logic        irq_any;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   always #5 clk = ~clk;

   ql_irq_ctrl #(.N(N), .PEND_IPL(PEND), .MODE_RST(MRST)) dut (
      .clk(clk), .reset(reset), .cen(cen), .cpu_sel(cpu_sel), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .src(src),
      .ipc_ipl(ipc_ipl), .ipl(ipl), .irq_any(irq_any)
   );

   // ---------------- reference model ----------------
   logic [15:0] m_pend, m_mask, m_mode, m_prev, m_hs0, m_hs1;
   logic        m_irq;
   logic [1:0]  m_ipl;
   logic [15:0] n_pend, n_mask, n_mode, n_prev, n_hs0, n_hs1;
   logic        n_irq;
   logic [1:0]  n_ipl;
   logic [15:0] exp_dout;

   always_comb begin
      logic        we;
      logic [15:0] be, wd, s_now, g, hw_set, ack, sw;
      we     = cen & cpu_sel & cpu_wr;
      be     = {{8{cpu_uds}}, {8{cpu_lds}}};
      wd     = cpu_din & be;
      s_now  = (SYNC != 0) ? m_hs1 : src;
      g      = s_now & m_mask;
      hw_set = (m_mode & g) | (~m_mode & g & ~m_prev);
      ack    = (we && cpu_addr == 2'd0) ? wd : 16'h0000;
      sw     = (we && cpu_addr == 2'd3) ? wd : 16'h0000;
      n_irq  = (m_pend != 16'h0000);
      n_ipl  = n_irq ? (ipc_ipl & PEND) : ipc_ipl;
      n_pend = (m_pend & ~ack) | hw_set | sw;
      n_mask = (we && cpu_addr == 2'd1) ? ((m_mask & ~be) | wd) : m_mask;
      n_mode = (we && cpu_addr == 2'd2) ? ((m_mode & ~be) | wd) : m_mode;
      n_prev = g;
      n_hs0  = src;
      n_hs1  = m_hs0;
      if (reset) begin
         n_pend = 16'h0000; n_mask = 16'h0000; n_mode = MRST; n_prev = 16'h0000;
         n_hs0  = 16'h0000; n_hs1  = 16'h0000; n_irq  = 1'b0; n_ipl  = 2'b11;
      end
   end

   always @(posedge clk) begin
      m_pend <= n_pend; m_mask <= n_mask; m_mode <= n_mode; m_prev <= n_prev;
      m_hs0  <= n_hs0;  m_hs1  <= n_hs1;  m_irq  <= n_irq;  m_ipl  <= n_ipl;
   end

   always_comb begin
      case (cpu_addr)
         2'd0:    exp_dout = m_pend;
         2'd1:    exp_dout = m_mask;
         2'd2:    exp_dout = m_mode;
         default: exp_dout = (SYNC != 0) ? m_hs1 : src;
      endcase
   end

   // ---------------- checking ----------------
   function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_irq_any", {15'd0, irq_any}, {15'd0, m_irq});
         check("model_ipl",     {14'd0, ipl},     {14'd0, m_ipl});
         check("model_dout",    cpu_dout,         exp_dout);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic u = 1'b1, input logic l = 1'b1);
      cen = 1'b1; cpu_sel = 1'b1; cpu_wr = 1'b1;
      cpu_addr = a; cpu_din = d; cpu_uds = u; cpu_lds = l;
      tick();
      cen = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] a, input logic [15:0] e);
      cpu_addr = a;
      #1;
      check(nm, cpu_dout, e);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1; cen = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0;
      cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_din = 16'h0000;
      src = 16'hFFFF; ipc_ipl = 2'b10;
      tick_n(3);
      reset = 1'b0;
      chk_en = 1'b1;

      // Reset state with all sources high.
      rd_chk("rst_pending", 2'd0, 16'h0000);
      check("rst_ipl", {14'd0, ipl}, 16'h0003);
      check("rst_irq_any", {15'd0, irq_any}, 16'h0000);
      rd_chk("rst_mode", 2'd2, MRST);
      tick_n(SYNC + 1);
      rd_chk("rst_no_trigger", 2'd0, 16'h0000);

      // Unmask channel 0 while src[0] is high.
      wr(2'd1, 16'h0001);
      tick();
      rd_chk("unmask_pending", 2'd0, 16'h0001);
      tick();
      check("unmask_ipl", {14'd0, ipl}, 16'h0000);
      check("unmask_irq_any", {15'd0, irq_any}, 16'h0001);
      src = 16'h0000;
      wr(2'd1, 16'h0000);
      wr(2'd2, 16'h0000);
      wr(2'd0, 16'hFFFF);
      rd_chk("clean_pending", 2'd0, 16'h0000);
      tick_n(SYNC + 1);

      // Edge capture and acknowledge.
      wr(2'd1, 16'h0008);
      src = 16'h0008; tick(); src = 16'h0000; tick_n(SYNC);
      rd_chk("edge_pending", 2'd0, 16'h0008);
      tick_n(SYNC + 1);
      rd_chk("edge_held", 2'd0, 16'h0008);
      wr(2'd0, 16'h0008);
      rd_chk("edge_w1c", 2'd0, 16'h0000);
      tick();
      check("edge_ipl_release", {14'd0, ipl}, 16'h0002);
      check("edge_irq_drop", {15'd0, irq_any}, 16'h0000);
      src = 16'h0008; tick(); src = 16'h0000; tick_n(SYNC);
      rd_chk("edge_second", 2'd0, 16'h0008);
      tick_n(SYNC + 1);
      wr(2'd0, 16'h0008);

      // Level re-assert.
      wr(2'd2, 16'h0004);
      wr(2'd1, 16'h0004);
      src = 16'h0004; tick(); tick_n(SYNC);
      rd_chk("level_pending", 2'd0, 16'h0004);
      wr(2'd0, 16'h0004);
      tick();
      rd_chk("level_reassert", 2'd0, 16'h0004);
      src = 16'h0000; tick(); tick_n(SYNC);
      wr(2'd0, 16'h0004);
      rd_chk("level_cleared", 2'd0, 16'h0000);

      // Simultaneous set and ack: set wins.
      wr(2'd2, 16'h0000);
      wr(2'd1, 16'h0002);
      wr(2'd3, 16'h0002);
      src = 16'h0002; tick_n(SYNC);
      wr(2'd0, 16'h0002);
      rd_chk("set_beats_ack", 2'd0, 16'h0002);
      src = 16'h0000; tick(); tick_n(SYNC);
      wr(2'd0, 16'h0002);

      // Byte enables on software trigger and W1C.
      wr(2'd1, 16'h0000);
      wr(2'd3, 16'hFFFF, 1'b1, 1'b0);
      rd_chk("swset_uds", 2'd0, 16'hFF00);
      wr(2'd0, 16'hFFFF, 1'b0, 1'b1);
      rd_chk("w1c_lds_only", 2'd0, 16'hFF00);
      wr(2'd1, 16'h1234, 1'b0, 1'b1);
      rd_chk("mask_lds_only", 2'd1, 16'h0034);
      wr(2'd0, 16'hFFFF);
      wr(2'd1, 16'h0000);
      tick();

      // Source-to-pending latency.
      wr(2'd1, 16'h0010);
      src = 16'h0010;
      for (int t = 1; t <= LAT; t++) begin
         tick();
         rd_chk("latency", 2'd0, (t == LAT) ? 16'h0010 : 16'h0000);
      end
      src = 16'h0000; tick_n(SYNC + 1);
      wr(2'd0, 16'hFFFF);
      wr(2'd1, 16'h0000);

      // ipc_ipl passes through with one cycle of latency when idle.
      ipc_ipl = 2'b01;
      tick();
      check("ipc_latency", {14'd0, ipl}, 16'h0001);
      ipc_ipl = 2'b10;

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         reset    = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 3) == 0) src = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ipc_ipl = 2'($urandom);
         cen      = 1'($urandom);
         cpu_sel  = ($urandom_range(0, 3) != 0);
         cpu_wr   = ($urandom_range(0, 2) == 0);
         cpu_addr = 2'($urandom);
         cpu_din  = 16'($urandom);
         cpu_uds  = ($urandom_range(0, 3) != 0);
         cpu_lds  = ($urandom_range(0, 3) != 0);
         tick();
      end
      reset = 1'b0; cen = 1'b0; cpu_wr = 1'b0;
      tick_n(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
